// File: rtl/ibex_pkg.sv
// ----------------------------------------------------------------------------
// ibex_pkg
// Shared types for the data-bus arbiter slice.
//   host_id_t   : 1-bit host identifier (0 = LSU, 1 = secondary master)
//   arb_state_e : arbiter FSM state (IDLE, WAIT_GNT)
// ----------------------------------------------------------------------------
package ibex_pkg;

    typedef logic host_id_t;

    localparam host_id_t HOST_LSU = 1'b0;
    localparam host_id_t HOST_SEC = 1'b1;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ibex_arb_id_fifo.sv
// ----------------------------------------------------------------------------
// ibex_arb_id_fifo
// Small FIFO of host IDs for transactions granted but not yet answered.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i, id_i  : enqueue the ID of a granted request (ignored when full)
//   pop_i         : dequeue the head (ignored when empty)
//   head_o        : ID of the oldest outstanding transaction
//   count_o       : number of stored IDs
//   full_o, empty_o
// ----------------------------------------------------------------------------
module ibex_arb_id_fifo import ibex_pkg::*; #(
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  host_id_t        id_i,
    input  logic            pop_i,
    output host_id_t        head_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    host_id_t        mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= HOST_LSU;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= id_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ibex_data_bus_arbiter.sv
// ----------------------------------------------------------------------------
// ibex_data_bus_arbiter
// Shares the core data-memory port between host 0 (LSU) and host 1
// (debug/DMA). One request is forwarded per grant; outstanding host IDs are
// queued so each response is routed back to the host that issued it.
// Ports:
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   h{0,1}_req/lock/addr/we/be/wdata_i : host request side
//   h{0,1}_gnt/rvalid/err/rdata_o  : host response side (rdata broadcast)
//   data_req/addr/we/be/wdata_o    : device request side
//   data_gnt/rvalid/err/rdata_i    : device response side
//   busy_o                         : transactions outstanding or request pending
//   protocol_err_o                 : sticky, response seen with nothing outstanding
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | arbitrate each cycle; a same-cycle grant stays here
// WAIT_GNT | request presented but not granted; mux frozen on sel_q
// ----------------------------------------------------------------------------
module ibex_data_bus_arbiter import ibex_pkg::*; #(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          ArbRoundRobin  = 1'b1,
    parameter int unsigned DataWidth      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 h0_req_i,
    input  logic                 h0_lock_i,
    input  logic [31:0]          h0_addr_i,
    input  logic                 h0_we_i,
    input  logic [3:0]           h0_be_i,
    input  logic [DataWidth-1:0] h0_wdata_i,
    output logic                 h0_gnt_o,
    output logic                 h0_rvalid_o,
    output logic                 h0_err_o,
    output logic [DataWidth-1:0] h0_rdata_o,
    input  logic                 h1_req_i,
    input  logic                 h1_lock_i,
    input  logic [31:0]          h1_addr_i,
    input  logic                 h1_we_i,
    input  logic [3:0]           h1_be_i,
    input  logic [DataWidth-1:0] h1_wdata_i,
    output logic                 h1_gnt_o,
    output logic                 h1_rvalid_o,
    output logic                 h1_err_o,
    output logic [DataWidth-1:0] h1_rdata_o,
    output logic                 data_req_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    input  logic                 data_err_i,
    output logic [31:0]          data_addr_o,
    output logic                 data_we_o,
    output logic [3:0]           data_be_o,
    output logic [DataWidth-1:0] data_wdata_o,
    input  logic [DataWidth-1:0] data_rdata_i,
    output logic                 busy_o,
    output logic                 protocol_err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    arb_state_e      state_q, state_d;
    host_id_t        sel_q, last_q, lock_owner_q;
    logic            lock_owner_valid_q;
    logic            protocol_err_q;

    logic            cand0, cand1;
    host_id_t        winner;
    host_id_t        cur_sel;
    logic            cur_lock;
    logic            req_raw;
    logic            grant;
    logic            pop;
    host_id_t        fifo_head;
    logic [CntW-1:0] fifo_count;
    logic            fifo_full, fifo_empty;

    ibex_arb_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .id_i    (cur_sel),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // While a lock is held only the owner is a candidate, so the other host
    // cannot slip in between the halves of a split access.
    always_comb begin
        cand0 = h0_req_i;
        cand1 = h1_req_i;
        if (lock_owner_valid_q) begin
            cand0 = h0_req_i && (lock_owner_q == HOST_LSU);
            cand1 = h1_req_i && (lock_owner_q == HOST_SEC);
        end
        if (cand0 && cand1) begin
            winner = ArbRoundRobin ? ~last_q : HOST_LSU;
        end else if (cand1) begin
            winner = HOST_SEC;
        end else begin
            winner = HOST_LSU;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (data_req_o && !data_gnt_i) state_d = WAIT_GNT;
            WAIT_GNT: if (data_gnt_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Throttle uses the registered FIFO state only, keeping rvalid off the
    // combinational path to data_req_o.
    always_comb begin
        req_raw = 1'b0;
        cur_sel = winner;
        case (state_q)
            IDLE: begin
                req_raw = (cand0 || cand1) && !fifo_full;
                cur_sel = winner;
            end
            WAIT_GNT: begin
                req_raw = 1'b1;
                cur_sel = sel_q;
            end
            default: ;
        endcase

        data_req_o = rst_ni && req_raw;
        grant      = data_req_o && data_gnt_i;
        h0_gnt_o   = grant && (cur_sel == HOST_LSU);
        h1_gnt_o   = grant && (cur_sel == HOST_SEC);
        cur_lock   = (cur_sel == HOST_SEC) ? h1_lock_i : h0_lock_i;

        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_wdata_o = '0;
        if (data_req_o) begin
            data_addr_o  = (cur_sel == HOST_SEC) ? h1_addr_i  : h0_addr_i;
            data_we_o    = (cur_sel == HOST_SEC) ? h1_we_i    : h0_we_i;
            data_be_o    = (cur_sel == HOST_SEC) ? h1_be_i    : h0_be_i;
            data_wdata_o = (cur_sel == HOST_SEC) ? h1_wdata_i : h0_wdata_i;
        end

        pop         = rst_ni && data_rvalid_i && !fifo_empty;
        h0_rvalid_o = pop && (fifo_head == HOST_LSU);
        h1_rvalid_o = pop && (fifo_head == HOST_SEC);
        h0_err_o    = h0_rvalid_o && data_err_i;
        h1_err_o    = h1_rvalid_o && data_err_i;
        h0_rdata_o  = rst_ni ? data_rdata_i : '0;
        h1_rdata_o  = rst_ni ? data_rdata_i : '0;

        busy_o = rst_ni && ((fifo_count != '0) || h0_req_i || h1_req_i ||
                            (state_q == WAIT_GNT));
        protocol_err_o = protocol_err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q              <= HOST_LSU;
            last_q             <= HOST_SEC;
            lock_owner_valid_q <= 1'b0;
            lock_owner_q       <= HOST_LSU;
            protocol_err_q     <= 1'b0;
        end else begin
            if ((state_q == IDLE) && data_req_o && !data_gnt_i) begin
                sel_q <= winner;
            end
            if (grant) begin
                last_q <= cur_sel;
                if (cur_lock) begin
                    lock_owner_valid_q <= 1'b1;
                    lock_owner_q       <= cur_sel;
                end else if (lock_owner_valid_q && (lock_owner_q == cur_sel)) begin
                    lock_owner_valid_q <= 1'b0;
                end
            end
            if (data_rvalid_i && fifo_empty) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ibex_data_bus_arbiter.md
Name: ibex_data_bus_arbiter

Overview:
Two-host arbiter that shares the single core data-memory port between the load/store unit (host 0) and a secondary master (host 1, e.g. debug/DMA). It forwards one request per grant and tracks outstanding transactions in an ID FIFO so that each response is returned to the host that issued it. It holds a request stable until granted and honours a lock so that split misaligned accesses complete back-to-back. It sits between the LSU and the top-level data bus.

Parameters:
MaxOutstanding, 2, depth of the outstanding-ID FIFO (1..4)
ArbRoundRobin, 1'b1, 1 = round-robin between hosts; 0 = fixed priority, host 0 wins
DataWidth, 32, data bus width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
h0_req_i / h1_req_i  in  1  host request
h0_lock_i / h1_lock_i  in  1  keep ownership after the current grant (split access in progress)
h0_addr_i / h1_addr_i  in  32  word-aligned address
h0_we_i / h1_we_i  in  1  write enable
h0_be_i / h1_be_i  in  4  byte enables
h0_wdata_i / h1_wdata_i  in  DataWidth  write data
h0_gnt_o / h1_gnt_o  out  1  request accepted
h0_rvalid_o / h1_rvalid_o  out  1  response valid
h0_err_o / h1_err_o  out  1  bus error, qualified by rvalid
h0_rdata_o / h1_rdata_o  out  DataWidth  read data, broadcast to both hosts
data_req_o  out  1  device request
data_gnt_i  in  1  device grant
data_rvalid_i  in  1  device response
data_err_i  in  1  device error
data_addr_o  out  32  muxed address
data_we_o  out  1  muxed write enable
data_be_o  out  4  muxed byte enables
data_wdata_o  out  DataWidth  muxed write data
data_rdata_i  in  DataWidth  device read data
busy_o  out  1  outstanding count != 0, or a request is pending
protocol_err_o  out  1  sticky: rvalid received with an empty FIFO

Behaviour:
- Reset: state IDLE; sel_q=0; last_q=1 (host 0 wins the first tie); lock_owner_valid_q=0; FIFO empty; count=0; protocol_err_o=0. All outputs are 0 during reset.
- States: IDLE and WAIT_GNT.
  - IDLE: if any request is present and count<MaxOutstanding, pick a winner combinationally, drive data_req_o=1 and mux the winner's address, we, be and wdata.
    - On data_gnt_i in the same cycle: pulse the winner's gnt, push its ID, and stay in IDLE.
    - Otherwise: latch sel_q=winner and go to WAIT_GNT.
  - WAIT_GNT: data_req_o=1; the mux is driven from sel_q with no re-arbitration. On data_gnt_i, pulse gnt[sel_q], push the ID, and go to IDLE.
  - Dropping a request while in WAIT_GNT is a protocol violation by the host. The arbiter keeps data_req_o asserted and does not check the violation.
- Winner selection:
  - A locked owner (lock_owner_valid_q) wins whenever it requests. The other host is never granted while the lock is held.
  - Otherwise, with ArbRoundRobin=1, a single requester wins; if both request, the host != last_q wins. With ArbRoundRobin=0, host 0 always wins a tie.
  - last_q updates on every grant.
- Lock:
  - Grant with h*_lock_i=1: set lock_owner_valid_q and record the owner.
  - Grant to the owner with lock_i=0: clear the lock.
- Throttling: data_req_o is gated on the registered count only. A pop in the same cycle does not allow a push when the FIFO is full, so there is no combinational path from rvalid to req.
- Response routing:
  - data_rvalid_i pops the FIFO head ID and drives h{ID}_rvalid_o=1 and h{ID}_err_o=data_err_i in the same cycle, with zero latency.
  - Push and pop in the same cycle leave count unchanged.
  - rvalid with the FIFO empty: no host rvalid, and protocol_err_o sets (sticky until reset).
- Grant and rvalid are combinational from the data_* inputs. Only the FIFO, count, sel_q, last_q and lock are registered.
- Reset mid-operation discards all outstanding IDs. Responses that arrive after reset are flagged via protocol_err_o.

Decomposition:
- Shared package ibex_pkg: host ID type (1 bit) and the arbiter state enum (IDLE, WAIT_GNT).
- One sub-module, ibex_arb_id_fifo: parameterised depth, push/pop, count, full/empty, asynchronous active-low reset.

Test Plan:
- Back-to-back contention: both hosts request with data_gnt_i=1 every cycle, ArbRoundRobin=1 -> grants alternate h0,h1,h0,h1. Responses in order route rvalid to h0,h1,h0,h1.
- Held request: h1 alone, data_gnt_i low for 3 cycles, then h0 also requests -> data_addr_o stays at h1's address and h1_gnt_o pulses on cycle 4; h0 is granted next.
- Lock: h0 requests with lock=1, granted; h1 requests continuously -> h1 is not granted until h0's second request (lock=0) is granted.
- Throttle: MaxOutstanding=2, two grants with no rvalid -> data_req_o=0 with a pending request. After one rvalid, data_req_o=1 in the next cycle.
- Error and protocol error: rvalid with data_err_i=1 for an h1 ID -> h1_err_o=1 and h0 sees no rvalid. An extra rvalid with an empty FIFO -> protocol_err_o=1 and it stays set.
- Reset: assert rst_ni=0 with 2 outstanding -> count=0, data_req_o=0, and all gnt and rvalid outputs are 0 immediately.
